// File: rtl/uart_imem_loader_pkg.sv
// rtl/uart_imem_loader_pkg.sv - shared types and constants for the UART program loader
package uart_imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] HEADER = 8'hA5;

  function automatic int unsigned calc_cpb(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_imem_loader_rx_byte.sv
// rtl/uart_imem_loader_rx_byte.sv - 8N1 byte receiver with input synchronizer
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CPB = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       ferr_o
);

  localparam int unsigned CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);

  rx_state_e       state_q, state_d;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // A start bit that is no longer low at mid-bit is treated as a glitch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (prev_q && !sync2_q) state_d = RX_START;
      RX_START: if (cnt_q == HALF_M1) state_d = sync2_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_q == FULL_M1 && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_q == FULL_M1) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: cnt_d = '0;
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign byte_o  = shift_q;
  assign valid_o = valid_q;
  assign ferr_o  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// rtl/uart_imem_loader.sv - framed UART program loader driving the instruction-memory write port
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned CPB = calc_cpb(CLK_HZ, BAUD);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_ferr;

  uart_rx_byte #(.CPB(CPB)) u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .rx_i    (rx_i),
    .byte_o  (rx_byte),
    .valid_o (rx_valid),
    .ferr_o  (rx_ferr)
  );

  ld_state_e         state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              hold_q, hold_d;
  logic              word_end, last_byte, frame_abort;

  assign word_end    = (byte_idx_q == 2'd3);
  assign last_byte   = word_end && ({1'b0, word_cnt_q} + 9'd1 == {1'b0, len_q});
  assign frame_abort = rx_ferr && (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      wbuf_q     <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      wbuf_q     <= wbuf_d;
      sum_q      <= sum_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_abort) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (rx_byte == HEADER) state_d = ST_LEN;
        ST_LEN:  state_d = (rx_byte == 8'd0) ? ST_CSUM : ST_DATA;
        ST_DATA: if (last_byte) state_d = ST_CSUM;
        ST_CSUM: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The address advances on the edge that ends the write strobe.
  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    wbuf_d     = wbuf_q;
    sum_d      = sum_q;
    addr_d     = we_q ? addr_q + ADDR_W'(1) : addr_q;
    we_d       = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    hold_d     = hold_q;
    if (frame_abort) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
      hold_d = 1'b1;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == HEADER) begin
            done_d     = 1'b0;
            err_d      = 1'b0;
            busy_d     = 1'b1;
            hold_d     = 1'b1;
            addr_d     = '0;
            sum_d      = '0;
            word_cnt_d = '0;
            byte_idx_d = '0;
          end
        end
        ST_LEN: len_d = rx_byte;
        ST_DATA: begin
          wbuf_d[{byte_idx_q, 3'b000} +: 8] = rx_byte;
          sum_d      = sum_q + rx_byte;
          byte_idx_d = byte_idx_q + 2'd1;
          if (word_end) begin
            we_d       = 1'b1;
            word_cnt_d = word_cnt_q + 8'd1;
          end
        end
        ST_CSUM: begin
          busy_d = 1'b0;
          if (rx_byte == sum_q) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        default: busy_d = 1'b0;
      endcase
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wbuf_q;
  assign cpu_rstn_o   = ~hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// tb/tb_uart_imem_loader.sv - self-checking bench for uart_imem_loader
module tb_uart_imem_loader;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx_i;
  logic        imem_we_o;
  logic [3:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_rstn_o, busy_o, done_o, err_o;

  uart_imem_loader #(.CLK_HZ(16), .BAUD(1), .ADDR_W(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_i         (rx_i),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_rstn_o   (cpu_rstn_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  logic [35:0] wr_log[$];
  always @(negedge clk) if (imem_we_o) wr_log.push_back({imem_addr_o, imem_wdata_o});

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] words [0:31];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_low);
    @(negedge clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_i = ~stop_low;
    repeat (CPB) @(negedge clk);
    rx_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_delta);
    logic [7:0] sum;
    logic [7:0] b;
    logic [31:0] w32;
    sum = 8'd0;
    wr_log.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(n[7:0], 1'b0);
    for (int w = 0; w < n; w++) begin
      w32 = words[w];
      for (int k = 0; k < 4; k++) begin
        b = w32[8*k +: 8];
        sum = sum + b;
        send_byte(b, 1'b0);
      end
    end
    send_byte(sum + csum_delta, 1'b0);
  endtask

  task automatic check_writes(input string tag, input int n);
    logic [35:0] e;
    check({tag, "_count"}, wr_log.size(), n);
    for (int w = 0; w < n && w < wr_log.size(); w++) begin
      e = wr_log[w];
      check({tag, "_addr"}, e[35:32], w % 16);
      check({tag, "_data"}, e[31:0], words[w]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, imem_we_o, 1'b0);
    check({tag, "_addr"}, imem_addr_o, 4'd0);
    check({tag, "_wdata"}, imem_wdata_o, 32'd0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
    check({tag, "_cpu_rstn"}, cpu_rstn_o, 1'b1);
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic c);
    check({tag, "_done"}, done_o, d);
    check({tag, "_err"}, err_o, e);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_cpu_rstn"}, cpu_rstn_o, c);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    check_reset_vals("idle");
    check("idle_writes", wr_log.size(), 0);

    words[0] = 32'h0000_0013;
    words[1] = 32'h0010_8093;
    send_frame(2, 8'd0);
    check_writes("good", 2);
    check_flags("good", 1'b1, 1'b0, 1'b1);

    send_frame(2, 8'd1);
    check_writes("badcs", 2);
    check_flags("badcs", 1'b0, 1'b1, 1'b0);
    send_frame(2, 8'd0);
    check_writes("resend", 2);
    check_flags("resend", 1'b1, 1'b0, 1'b1);

    wr_log.delete();
    send_byte(8'h55, 1'b0);
    send_byte(8'hFF, 1'b0);
    check("stray_writes", wr_log.size(), 0);
    check_flags("stray", 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'd0);
    check("empty_writes", wr_log.size(), 0);
    check_flags("empty", 1'b1, 1'b0, 1'b1);

    wr_log.delete();
    send_byte(8'hA5, 1'b0);
    check("hdr_busy", busy_o, 1'b1);
    check("hdr_done", done_o, 1'b0);
    check("hdr_cpu_rstn", cpu_rstn_o, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b1);
    check("ferr_writes", wr_log.size(), 0);
    check_flags("ferr", 1'b0, 1'b1, 1'b0);
    words[0] = $urandom;
    words[1] = $urandom;
    send_frame(2, 8'd0);
    check_writes("after_ferr", 2);
    check_flags("after_ferr", 1'b1, 1'b0, 1'b1);

    words[0] = $urandom;
    words[1] = $urandom;
    wr_log.delete();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 1'b0);
    send_byte(words[1][7:0], 1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_vals("midrst");
    check_writes("midrst", 1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);

    n = $urandom_range(17, 20);
    for (int w = 0; w < n; w++) words[w] = $urandom;
    words[0][7:0] = 8'hA5;
    send_frame(n, 8'd0);
    check_writes("wrap", n);
    check_flags("wrap", 1'b1, 1'b0, 1'b1);

    n = $urandom_range(1, 3);
    for (int w = 0; w < n; w++) words[w] = $urandom;
    send_frame(n, 8'($urandom_range(1, 255)));
    check_writes("randbad", n);
    check_flags("randbad", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
# uart_imem_loader

Serial program loader for the pipelined CPU. It receives a framed program image over a UART line, assembles little-endian 32-bit words, and drives the write side of instruction memory, which the CPU only ever reads. While a load is in progress it holds the CPU in reset, and it releases the CPU only after the image's checksum passes. It sits beside the instruction memory at the board top, on the same clock as the clock divider.

## Interface
Parameters:
- CLK_HZ, 100000000: frequency of clk in Hz.
- BAUD, 115200: serial bit rate.
- ADDR_W, 8: width of the instruction-memory word address.

Ports:
- clk, input, 1: system clock; the single clock domain.
- rstn, input, 1: asynchronous, active-low reset.
- rx_i, input, 1: UART receive line, 8N1, idles high, asynchronous to clk.
- imem_we_o, output, 1: one-cycle word write strobe.
- imem_addr_o, output, ADDR_W: word address of the current write.
- imem_wdata_o, output, 32: word to write.
- cpu_rstn_o, output, 1: active-low reset to the CPU core.
- busy_o, output, 1: a frame is being received.
- done_o, output, 1: the last frame loaded with a good checksum.
- err_o, output, 1: the last frame failed.

## Operation
- Frame format: header byte 0xA5, then length N (word count, 0..255), then 4·N data bytes (LSB first per word), then checksum byte.
- Checksum: the 8-bit sum, mod 256, of all data bytes only.
- rx_i passes through a 2-flop synchronizer before any use.
- Byte receiver:
  - CPB = CLK_HZ/BAUD, integer division.
  - A falling edge starts a frame; the start bit is re-checked low at CPB/2, else the receiver returns to idle.
  - Data bits are sampled every CPB after that, LSB first.
  - A stop bit read low is a framing error.
- Loader FSM states: IDLE, LEN, DATA, CSUM.
  - IDLE: bytes other than 0xA5 are ignored. On 0xA5, go to LEN; clear done_o and err_o; set busy_o; force cpu_rstn_o low; reset the address to 0.
  - LEN: latch N and go to DATA. If N=0, go straight to CSUM.
  - DATA: shift each byte into bits [8k+7:8k] of the word buffer, k = 0..3. After byte 3, pulse imem_we_o for one cycle, then increment the address. After word N, go to CSUM.
  - CSUM: compare the received byte with the running sum.
    - Match: done_o=1, cpu_rstn_o=1.
    - Mismatch: err_o=1, cpu_rstn_o stays 0.
    - Either way: busy_o=0, return to IDLE.
- A framing error in any state except IDLE sets err_o and returns to IDLE with cpu_rstn_o held low. The errored byte is discarded.
- After an error, the CPU stays in reset until a frame completes with a good checksum.
- A 0xA5 that arrives inside DATA is treated as data, not as a new header.
- imem_addr_o wraps modulo 2^ADDR_W if N·1 exceeds the memory depth. No error is flagged for this.

## Timing
- Reset values: imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, busy_o=0, done_o=0, err_o=0, cpu_rstn_o=1. Out of reset the CPU runs the built-in image.
- Reset mid-frame aborts the frame immediately and restores all reset values. Words already written stay in memory.
- Byte-valid rises 1 clk after the stop-bit mid-sample.
- imem_we_o is asserted the clk after byte-valid for byte 3. imem_addr_o and imem_wdata_o are stable during that cycle.
- The address increments on the clock edge that ends the strobe.
- done_o, err_o and cpu_rstn_o update on the clk after the checksum byte-valid.
- done_o and err_o are sticky levels. They clear only on the next header or on reset.
- The line-to-byte-valid latency must not exceed 10·CPB + CPB/2 + 4 clk.

## Structure
- Shared package holds:
  - FSM state encoding (2-bit: IDLE=0, LEN=1, DATA=2, CSUM=3).
  - Header constant 8'hA5.
  - The CPB computation.
- Sub-module uart_rx_byte: synchronizer, bit timer, and shift register, with outputs byte_o[7:0], valid_o (1-cycle) and ferr_o (1-cycle).
- The top holds the FSM, byte index, word counter, checksum accumulator, address counter and CPU-reset hold flag.

## Test plan
All scenarios use CLK_HZ=16, BAUD=1, ADDR_W=4, so CPB=16.
- Reset then idle line: all outputs at reset values; cpu_rstn_o=1 throughout.
- Frame A5, 02, 13 00 00 00, 93 80 10 00, checksum 0x36:
  - two strobes: addr 0 data 0x00000013, then addr 1 data 0x00108093;
  - done_o=1, cpu_rstn_o=1.
- Same frame with checksum 0x37: both writes occur; err_o=1, done_o=0, cpu_rstn_o=0. A correct resend afterwards sets done_o=1 and releases the CPU.
- Stray bytes 0x55, 0xFF before the header: no writes and no state change. Frame A5, 00, 00: done_o=1 with no strobes.
- Stop bit driven low on the 2nd data byte: err_o=1, busy_o=0, no strobe. The next good frame loads starting at addr 0.
- rstn pulsed low after 5 data bytes: outputs return to reset values within the same cycle. Exactly one strobe (addr 0) occurred before the reset.
